task_3_latency_stats: RTL

- Sits directly downstream of the task-3 latency measurement stage and consumes its latency word and valid pulse.
- Converts the cumulative busy-cycle count into per-measurement latencies.
- Accumulates min/max/sum over a window of 2^WINDOW_LOG2 measurements, then publishes min, max and floor-average with a one-cycle strobe.
- Results feed the task-3 reporting/readout logic.

---
 rtl/task_3_latency_stats_if.sv | 29 ++
 rtl/task_3_latency_stats.sv | 121 ++++++++++++
 2 files changed

// File: rtl/task_3_latency_stats_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | task_3_latency_stats_if : latency-stats bus; revision 1.0                |
// +--------------------------------------------------------------------------+
interface task_3_latency_stats_if #(
  parameter int LAT_W = 24,
  parameter int CNT_W = 16
);
  logic [LAT_W-1:0] i_lat;
  logic             i_lat_valid;
  logic             i_clear;
  logic [LAT_W-1:0] o_last;
  logic [LAT_W-1:0] o_min;
  logic [LAT_W-1:0] o_max;
  logic [LAT_W-1:0] o_avg;
  logic [CNT_W-1:0] o_win_cnt;
  logic             o_stats_valid;

  modport master (
    output i_lat, i_lat_valid, i_clear,
    input  o_last, o_min, o_max, o_avg, o_win_cnt, o_stats_valid
  );

  modport slave (
    input  i_lat, i_lat_valid, i_clear,
    output o_last, o_min, o_max, o_avg, o_win_cnt, o_stats_valid
  );
endinterface
`default_nettype wire

// File: rtl/task_3_latency_stats.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | task_3_latency_stats : windowed min/max/avg of per-sample latency; r1.0  |
// +--------------------------------------------------------------------------+
module task_3_latency_stats #(
  parameter int DATA_WIDTH        = 8,
  parameter int LAT_SIZE_IN_WIDTH = 3,
  parameter int WINDOW_LOG2       = 3,
  parameter int CNT_W             = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  task_3_latency_stats_if.slave  bus
);
  localparam int LAT_W   = DATA_WIDTH * LAT_SIZE_IN_WIDTH;
  localparam int c_SUM_W = LAT_W + WINDOW_LOG2;
  localparam int c_SCNT_W = WINDOW_LOG2 + 1;
  localparam logic [c_SCNT_W-1:0] c_WIN_LAST = c_SCNT_W'((2 ** WINDOW_LOG2) - 1);

  logic [LAT_W-1:0]    base_q, base_d, last_q, last_d;
  logic [LAT_W-1:0]    run_min_q, run_min_d, run_max_q, run_max_d;
  logic [LAT_W-1:0]    min_q, min_d, max_q, max_d, avg_q, avg_d;
  logic [c_SUM_W-1:0]  sum_q, sum_d;
  logic [c_SCNT_W-1:0] scnt_q, scnt_d;
  logic [CNT_W-1:0]    win_cnt_q, win_cnt_d;
  logic                s1_vld_q, s1_vld_d, stats_vld_q, stats_vld_d;

  logic [LAT_W-1:0]    w_delta, w_min_nxt, w_max_nxt;
  logic [c_SUM_W-1:0]  w_sum_nxt;
  logic                w_win_done;

  // Modular subtraction makes counter wrap-around of the busy-cycle count transparent.
  assign w_delta    = bus.i_lat - base_q;
  assign w_sum_nxt  = sum_q + c_SUM_W'(last_q);
  assign w_min_nxt  = (last_q < run_min_q) ? last_q : run_min_q;
  assign w_max_nxt  = (last_q > run_max_q) ? last_q : run_max_q;
  assign w_win_done = (scnt_q == c_WIN_LAST);

  always_comb begin
    base_d      = base_q;
    last_d      = last_q;
    run_min_d   = run_min_q;
    run_max_d   = run_max_q;
    min_d       = min_q;
    max_d       = max_q;
    avg_d       = avg_q;
    sum_d       = sum_q;
    scnt_d      = scnt_q;
    win_cnt_d   = win_cnt_q;
    stats_vld_d = 1'b0;
    s1_vld_d    = bus.i_lat_valid & ~bus.i_clear;

    if (bus.i_lat_valid) begin
      base_d = bus.i_lat;
      last_d = w_delta;
    end

    if (bus.i_clear) begin
      scnt_d    = '0;
      sum_d     = '0;
      run_min_d = '1;
      run_max_d = '0;
    end else if (s1_vld_q) begin
      if (w_win_done) begin
        // Final sample is folded in combinationally so the window publishes this edge.
        min_d       = w_min_nxt;
        max_d       = w_max_nxt;
        avg_d       = w_sum_nxt[c_SUM_W-1:WINDOW_LOG2];
        win_cnt_d   = win_cnt_q + CNT_W'(1);
        stats_vld_d = 1'b1;
        scnt_d      = '0;
        sum_d       = '0;
        run_min_d   = '1;
        run_max_d   = '0;
      end else begin
        scnt_d    = scnt_q + c_SCNT_W'(1);
        sum_d     = w_sum_nxt;
        run_min_d = w_min_nxt;
        run_max_d = w_max_nxt;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      base_q      <= '0;
      last_q      <= '0;
      run_min_q   <= '1;
      run_max_q   <= '0;
      min_q       <= '0;
      max_q       <= '0;
      avg_q       <= '0;
      sum_q       <= '0;
      scnt_q      <= '0;
      win_cnt_q   <= '0;
      s1_vld_q    <= 1'b0;
      stats_vld_q <= 1'b0;
    end else begin
      base_q      <= base_d;
      last_q      <= last_d;
      run_min_q   <= run_min_d;
      run_max_q   <= run_max_d;
      min_q       <= min_d;
      max_q       <= max_d;
      avg_q       <= avg_d;
      sum_q       <= sum_d;
      scnt_q      <= scnt_d;
      win_cnt_q   <= win_cnt_d;
      s1_vld_q    <= s1_vld_d;
      stats_vld_q <= stats_vld_d;
    end
  end

  assign bus.o_last        = last_q;
  assign bus.o_min         = min_q;
  assign bus.o_max         = max_q;
  assign bus.o_avg         = avg_q;
  assign bus.o_win_cnt     = win_cnt_q;
  assign bus.o_stats_valid = stats_vld_q;
endmodule
`default_nettype wire
